binary_bbox_tracker: RTL and testbench
======================================

# binary_bbox_tracker

Consumes the thresholded binary pixel stream (12-bit, 0 or 4095) from the gray-to-binary stage. Per frame it computes the bounding box and the white-pixel count of all foreground pixels. At frame end it publishes the results with a one-cycle ready strobe. It sits directly downstream of binarisation and feeds the overlay/object-tracking logic.

## Interface
Parameters:
- H_ACTIVE, 640, active pixels per line; X counter wraps here.
- V_ACTIVE, 480, active lines per frame; pixels at Y ≥ V_ACTIVE are ignored.
- MIN_PIXELS, 16, minimum white count for oFOUND=1.

Ports:
- iCLK  in  1  pixel clock.
- iRST  in  1  asynchronous, active-low reset.
- iFVAL  in  1  frame valid; high for the whole frame.
- iDVAL  in  1  pixel valid qualifier from the binarisation stage.
- iDATA  in  12  binary pixel; white = any nonzero value.
- oX_MIN, oX_MAX, oY_MIN, oY_MAX  out  12 each  bounding box of the last completed frame.
- oCOUNT  out  20  white-pixel count of the last frame; saturates at 20'hFFFFF.
- oFOUND  out  1  high when oCOUNT ≥ MIN_PIXELS.
- oRDY  out  1  one-cycle strobe when the results update.

## Operation
- A pixel is accepted only on a posedge where iFVAL=1 and iDVAL=1 are sampled together. iDVAL outside iFVAL is ignored.
- X/Y counters (12-bit):
  - X increments on each accepted pixel.
  - At X=H_ACTIVE-1, X wraps to 0 and Y increments.
  - Once Y reaches V_ACTIVE, it holds and further pixels are ignored.
- Running accumulators per frame:
  - xmin and ymin initialise to 12'hFFF; xmax and ymax initialise to 0; count initialises to 0.
  - On each accepted white pixel: xmin=min(xmin,X), xmax=max(xmax,X), ymin=min(ymin,Y), ymax=max(ymax,Y), count+1 (saturating).
- State machine (fval_d is iFVAL registered):
  - WAIT_SOF: counters idle. Leave to ACCUM on iFVAL=1 && fval_d=0; the X/Y counters and accumulators are cleared in that transition cycle.
  - ACCUM: accumulate. On iFVAL=0 && fval_d=1, go to PUBLISH.
  - PUBLISH: one cycle. Outputs load from the accumulators, oRDY=1, then return to WAIT_SOF.
- Publish rules:
  - If count ≥ MIN_PIXELS: box outputs take the accumulator values and oFOUND=1.
  - Otherwise: box outputs are 0, oFOUND=0, and oCOUNT still reports the true count.
- Results hold until the next PUBLISH.

## Timing
- Reset (async, iRST=0): all outputs 0, state WAIT_SOF, fval_d=0, accumulators at their init values.
- A frame is accumulated only after a rising iFVAL edge is observed. If reset releases mid-frame, that frame is skipped entirely and no oRDY is issued for it.
- The first pixel of a frame may arrive in the same cycle that iFVAL rises. The clear must not drop it: the clear and the first accumulate merge.
- A pixel sampled on the same edge where iFVAL reads 0 is not counted.
- Latency: outputs and oRDY are valid on the second posedge after iFVAL is sampled low: one edge detects the fall, the next publishes. oRDY is high for exactly one cycle.
- If iFVAL falls mid-line, the partial line counts as normal and publishing proceeds as usual.
- A frame with zero accepted pixels still publishes: count=0, oFOUND=0, box outputs 0.
- Back-to-back frames with a one-cycle iFVAL low gap must both publish.

## Structure
- Shared package: coordinate width (12), count width (20), the state encoding (WAIT_SOF/ACCUM/PUBLISH), and the white-pixel predicate.
- One natural sub-module, `pixel_xy_counter`: the X/Y raster counter with the wrap and V_ACTIVE hold logic.
- The min/max/count accumulators and the FSM stay in the top level.

## Test plan
- Reset mid-frame: assert iRST during ACCUM, release mid-frame → all outputs 0 immediately; no oRDY until the next full frame completes.
- All-black 640×480 frame → oRDY once; oCOUNT=0, oFOUND=0, box outputs 0.
- Single white pixel at (5,3) plus 20 white pixels spanning (100..119, 200) → oX_MIN=5, oX_MAX=119, oY_MIN=3, oY_MAX=200, oCOUNT=21, oFOUND=1.
- All-white frame → box (0,639,0,479), oCOUNT=307200; extra DVAL pulses beyond line 480 are not counted.
- 10 white pixels with MIN_PIXELS=16 → oCOUNT=10, oFOUND=0, box outputs 0.
- iFVAL falls after X=300 on line 7, then rises again after a one-cycle gap → the first frame publishes with oY_MAX ≤ 7; the second frame starts with cleared counters and publishes independently.

Source files
------------

// File: rtl/binary_bbox_tracker_pkg.sv
// Shared widths, FSM encoding and pixel predicate for the binary bounding-box tracker.
package binary_bbox_tracker_pkg;

  localparam int unsigned COORD_W = 12;
  localparam int unsigned COUNT_W = 20;

  localparam logic [COORD_W-1:0] COORD_MIN_INIT = '1;
  localparam logic [COUNT_W-1:0] COUNT_SAT      = '1;

  typedef enum logic [1:0] {
    WAIT_SOF = 2'd0,
    ACCUM    = 2'd1,
    PUBLISH  = 2'd2
  } state_t;

  function automatic logic is_white(input logic [11:0] data);
    return |data;
  endfunction

endpackage

// File: rtl/pixel_xy_counter.sv
// Raster X/Y counter: X wraps at H_ACTIVE, Y holds once it reaches V_ACTIVE.
module pixel_xy_counter
  import binary_bbox_tracker_pkg::*;
#(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned V_ACTIVE = 480
) (
  input  logic               iCLK,
  input  logic               iRST,
  input  logic               i_clr,
  input  logic               i_adv,
  output logic [COORD_W-1:0] o_x,
  output logic [COORD_W-1:0] o_y,
  output logic               o_in_frame
);

  localparam logic [COORD_W-1:0] X_LAST = COORD_W'(H_ACTIVE - 1);
  localparam logic [COORD_W-1:0] Y_END  = COORD_W'(V_ACTIVE);

  logic [COORD_W-1:0] r_x;
  logic [COORD_W-1:0] r_y;
  logic [COORD_W-1:0] w_x;
  logic [COORD_W-1:0] w_y;

  // A clear presents (0,0) to the current pixel so the first pixel of a frame is not lost.
  always_comb begin
    w_x = i_clr ? '0 : r_x;
    w_y = i_clr ? '0 : r_y;
  end

  assign o_x        = w_x;
  assign o_y        = w_y;
  assign o_in_frame = (w_y < Y_END);

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      r_x <= '0;
      r_y <= '0;
    end else begin
      r_x <= w_x;
      r_y <= w_y;
      if (i_adv && o_in_frame) begin
        if (w_x == X_LAST) begin
          r_x <= '0;
          r_y <= w_y + 1'b1;
        end else begin
          r_x <= w_x + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/binary_bbox_tracker.sv
// Per-frame bounding box and white-pixel count of a binary pixel stream, published on frame end.
module binary_bbox_tracker
  import binary_bbox_tracker_pkg::*;
#(
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned MIN_PIXELS = 16
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iFVAL,
  input  logic        iDVAL,
  input  logic [11:0] iDATA,
  output logic [11:0] oX_MIN,
  output logic [11:0] oX_MAX,
  output logic [11:0] oY_MIN,
  output logic [11:0] oY_MAX,
  output logic [19:0] oCOUNT,
  output logic        oFOUND,
  output logic        oRDY
);

  state_t             r_state;
  logic               r_fval_d;
  logic               r_armed;
  logic [COORD_W-1:0] r_xmin, r_xmax, r_ymin, r_ymax;
  logic [COUNT_W-1:0] r_count;

  logic               w_sof, w_eof, w_adv, w_hit, w_in_frame, w_found;
  logic [COORD_W-1:0] w_x, w_y;
  logic [COORD_W-1:0] w_xmin_b, w_xmax_b, w_ymin_b, w_ymax_b;
  logic [COUNT_W-1:0] w_cnt_b;

  // r_armed requires iFVAL to be seen low after reset, so a frame in progress at reset release is skipped.
  // SOF is also honoured in PUBLISH so a one-cycle inter-frame gap does not lose the next frame.
  assign w_sof   = iFVAL && !r_fval_d && r_armed && (r_state != ACCUM);
  assign w_eof   = !iFVAL && r_fval_d && (r_state == ACCUM);
  assign w_adv   = iFVAL && iDVAL && (w_sof || (r_state == ACCUM));
  assign w_hit   = w_adv && w_in_frame && is_white(iDATA);
  assign w_found = ({12'd0, r_count} >= MIN_PIXELS);

  pixel_xy_counter #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE)
  ) u_xy (
    .iCLK       (iCLK),
    .iRST       (iRST),
    .i_clr      (w_sof),
    .i_adv      (w_adv),
    .o_x        (w_x),
    .o_y        (w_y),
    .o_in_frame (w_in_frame)
  );

  always_comb begin
    w_xmin_b = w_sof ? COORD_MIN_INIT : r_xmin;
    w_xmax_b = w_sof ? '0 : r_xmax;
    w_ymin_b = w_sof ? COORD_MIN_INIT : r_ymin;
    w_ymax_b = w_sof ? '0 : r_ymax;
    w_cnt_b  = w_sof ? '0 : r_count;
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      r_state  <= WAIT_SOF;
      r_fval_d <= 1'b0;
      r_armed  <= 1'b0;
      r_xmin   <= COORD_MIN_INIT;
      r_xmax   <= '0;
      r_ymin   <= COORD_MIN_INIT;
      r_ymax   <= '0;
      r_count  <= '0;
      oX_MIN   <= '0;
      oX_MAX   <= '0;
      oY_MIN   <= '0;
      oY_MAX   <= '0;
      oCOUNT   <= '0;
      oFOUND   <= 1'b0;
      oRDY     <= 1'b0;
    end else begin
      r_fval_d <= iFVAL;
      oRDY     <= 1'b0;
      if (!iFVAL) r_armed <= 1'b1;

      r_xmin  <= w_xmin_b;
      r_xmax  <= w_xmax_b;
      r_ymin  <= w_ymin_b;
      r_ymax  <= w_ymax_b;
      r_count <= w_cnt_b;
      if (w_hit) begin
        if (w_x < w_xmin_b) r_xmin <= w_x;
        if (w_x > w_xmax_b) r_xmax <= w_x;
        if (w_y < w_ymin_b) r_ymin <= w_y;
        if (w_y > w_ymax_b) r_ymax <= w_y;
        if (w_cnt_b != COUNT_SAT) r_count <= w_cnt_b + 1'b1;
      end

      case (r_state)
        WAIT_SOF: if (w_sof) r_state <= ACCUM;
        ACCUM:    if (w_eof) r_state <= PUBLISH;
        PUBLISH: begin
          oRDY   <= 1'b1;
          oCOUNT <= r_count;
          oFOUND <= w_found;
          oX_MIN <= w_found ? r_xmin : '0;
          oX_MAX <= w_found ? r_xmax : '0;
          oY_MIN <= w_found ? r_ymin : '0;
          oY_MAX <= w_found ? r_ymax : '0;
          r_state <= w_sof ? ACCUM : WAIT_SOF;
        end
        default: r_state <= WAIT_SOF;
      endcase
    end
  end

endmodule

// File: tb/tb_binary_bbox_tracker.sv
// Randomised frame stimulus checked against a pixel-index reference model of the tracker.
module tb_binary_bbox_tracker;

  localparam int H    = 32;
  localparam int V    = 24;
  localparam int MINP = 16;

  logic        iCLK  = 1'b0;
  logic        iRST  = 1'b0;
  logic        iFVAL = 1'b0;
  logic        iDVAL = 1'b0;
  logic [11:0] iDATA = '0;
  logic [11:0] oX_MIN, oX_MAX, oY_MIN, oY_MAX;
  logic [19:0] oCOUNT;
  logic        oFOUND, oRDY;

  always #5 iCLK = ~iCLK;

  binary_bbox_tracker #(
    .H_ACTIVE   (H),
    .V_ACTIVE   (V),
    .MIN_PIXELS (MINP)
  ) dut (
    .iCLK   (iCLK),
    .iRST   (iRST),
    .iFVAL  (iFVAL),
    .iDVAL  (iDVAL),
    .iDATA  (iDATA),
    .oX_MIN (oX_MIN),
    .oX_MAX (oX_MAX),
    .oY_MIN (oY_MIN),
    .oY_MAX (oY_MAX),
    .oCOUNT (oCOUNT),
    .oFOUND (oFOUND),
    .oRDY   (oRDY)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  always @(posedge iCLK) cyc <= cyc + 1;

  task automatic chk(input string tag, input int obs, input int want);
    n_vec++;
    if (obs !== want) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, want);
    end
  endtask

  typedef struct {
    int x0, x1, y0, y1, cnt, found, at;
  } res_t;

  res_t        exp_q[$];
  bit          fq_dv[$];
  logic [11:0] fq_dt[$];

  // Reference: the k-th accepted pixel sits at (k % H, k / H); pixels with k >= H*V are dropped.
  function automatic res_t model();
    res_t r;
    int k = 0, c = 0;
    int xmn = 4095, xmx = 0, ymn = 4095, ymx = 0;
    foreach (fq_dv[i]) begin
      if (fq_dv[i]) begin
        if (k < H * V) begin
          if (fq_dt[i] != 0) begin
            if (k % H < xmn) xmn = k % H;
            if (k % H > xmx) xmx = k % H;
            if (k / H < ymn) ymn = k / H;
            if (k / H > ymx) ymx = k / H;
            if (c < 1048575) c++;
          end
          k++;
        end
      end
    end
    r.cnt = c;
    r.at  = 0;
    if (c >= MINP) begin
      r.x0 = xmn; r.x1 = xmx; r.y0 = ymn; r.y1 = ymx; r.found = 1;
    end else begin
      r.x0 = 0; r.x1 = 0; r.y0 = 0; r.y1 = 0; r.found = 0;
    end
    return r;
  endfunction

  function automatic logic [11:0] white_val();
    return ($urandom_range(0, 3) == 0) ? 12'($urandom_range(1, 4095)) : 12'hFFF;
  endfunction

  // mode: 0 black, 1 all white, 2 (5,3) plus row 20 x=10..29, 3 first 10 white, 4 random with wp %
  task automatic build(input int mode, input int npix, input int bubble_pct, input int wp);
    bit w;
    fq_dv.delete();
    fq_dt.delete();
    for (int k = 0; k < npix; k++) begin
      while ($urandom_range(0, 99) < bubble_pct) begin
        fq_dv.push_back(1'b0);
        fq_dt.push_back(12'($urandom));
      end
      case (mode)
        1:       w = 1'b1;
        2:       w = (k == 3 * H + 5) || ((k / H == 20) && (k % H >= 10) && (k % H <= 29));
        3:       w = (k < 10);
        4:       w = ($urandom_range(0, 99) < wp);
        default: w = 1'b0;
      endcase
      fq_dv.push_back(1'b1);
      fq_dt.push_back(w ? white_val() : 12'h000);
    end
    if (fq_dv.size() == 0) begin
      for (int i = 0; i < 10; i++) begin
        fq_dv.push_back(1'b0);
        fq_dt.push_back(12'($urandom));
      end
    end
  endtask

  task automatic run_frame(input int gap, input bit expect_pub);
    res_t r;
    r = model();
    foreach (fq_dv[i]) begin
      @(negedge iCLK);
      iFVAL = 1'b1;
      iDVAL = fq_dv[i];
      iDATA = fq_dt[i];
    end
    for (int g = 0; g < gap; g++) begin
      @(negedge iCLK);
      iFVAL = 1'b0;
      iDVAL = 1'($urandom);
      iDATA = 12'($urandom);
      if (g == 0 && expect_pub) begin
        r.at = cyc + 2;
        exp_q.push_back(r);
      end
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_xmin"},  int'(oX_MIN), 0);
    chk({tag, "_xmax"},  int'(oX_MAX), 0);
    chk({tag, "_ymin"},  int'(oY_MIN), 0);
    chk({tag, "_ymax"},  int'(oY_MAX), 0);
    chk({tag, "_count"}, int'(oCOUNT), 0);
    chk({tag, "_found"}, int'(oFOUND), 0);
    chk({tag, "_rdy"},   int'(oRDY),   0);
  endtask

  always @(negedge iCLK) begin : monitor
    res_t e;
    if (oRDY) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_rdy", int'(oRDY), 0);
      end else begin
        e = exp_q.pop_front();
        chk("rdy_cycle", cyc,             e.at);
        chk("x_min",     int'(oX_MIN),    e.x0);
        chk("x_max",     int'(oX_MAX),    e.x1);
        chk("y_min",     int'(oY_MIN),    e.y0);
        chk("y_max",     int'(oY_MAX),    e.y1);
        chk("count",     int'(oCOUNT),    e.cnt);
        chk("found",     int'(oFOUND),    e.found);
      end
    end
  end

  initial begin
    int t;
    repeat (3) @(negedge iCLK);
    chk_zero("reset");

    // Reset released in the middle of a frame: that frame must be skipped.
    build(4, 300, 10, 50);
    foreach (fq_dv[i]) begin
      @(negedge iCLK);
      if (i == 6) iRST = 1'b1;
      iFVAL = 1'b1;
      iDVAL = fq_dv[i];
      iDATA = fq_dt[i];
    end
    repeat (3) begin
      @(negedge iCLK);
      iFVAL = 1'b0;
    end

    build(2, H * V, 10, 0);       run_frame(3, 1'b1);
    build(0, H * V, 0, 0);        run_frame(1, 1'b1);
    build(1, H * V + 40, 5, 0);   run_frame(2, 1'b1);
    build(3, 100, 10, 0);         run_frame(2, 1'b1);
    build(4, 7 * H + 21, 0, 40);  run_frame(1, 1'b1);
    build(4, 400, 0, 30);         run_frame(2, 1'b1);
    build(0, 0, 0, 0);            run_frame(1, 1'b1);
    build(4, 200, 5, 60);         run_frame(3, 1'b1);

    // Reset asserted during accumulation clears outputs at once and drops the frame.
    build(4, 300, 5, 50);
    foreach (fq_dv[i]) begin
      @(negedge iCLK);
      if (i == 150) begin
        iRST = 1'b0;
        #1;
        chk_zero("midrst");
      end
      if (i == 153) iRST = 1'b1;
      iFVAL = 1'b1;
      iDVAL = fq_dv[i];
      iDATA = fq_dt[i];
    end
    repeat (3) begin
      @(negedge iCLK);
      iFVAL = 1'b0;
    end

    for (int f = 0; f < 20; f++) begin
      build(4, $urandom_range(0, 850), $urandom_range(0, 30), $urandom_range(0, 60));
      run_frame($urandom_range(1, 3), 1'b1);
    end

    t = 0;
    while (exp_q.size() != 0 && t < 20) begin
      @(negedge iCLK);
      t++;
    end
    repeat (3) @(negedge iCLK);
    chk("pending_results", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
